// File: rtl/sram_sp_ctrl_pkg.sv
// Shared definitions for the single-port SRAM controller: byte geometry,
// a constant log2 helper and the byte-enable to bit-write-enable expansion.
package sram_ctrl_pkg;

  localparam int BYTE_W     = 8;
  localparam int MAX_DATA_W = 1024;
  localparam int MAX_BEN_W  = MAX_DATA_W / BYTE_W;

  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result = result + 1;
      rem    = rem >> 1;
    end
    return result;
  endfunction

  // Callers zero-extend their enables and truncate the result to their own width.
  function automatic logic [MAX_DATA_W-1:0] ben_to_wen(input logic [MAX_BEN_W-1:0] ben);
    logic [MAX_DATA_W-1:0] wen;
    for (int k = 0; k < MAX_BEN_W; k++) begin
      wen[k*BYTE_W +: BYTE_W] = {BYTE_W{~ben[k]}};
    end
    return wen;
  endfunction

endpackage

// File: rtl/sram_sp_ctrl_if.sv
// SoC-side request/response bundle of the SRAM controller.
// The master modport is the requester, the slave modport is the controller.
interface sram_sp_ctrl_if
  import sram_ctrl_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16384
);

  localparam int ADDR_W = clog2(DEPTH);
  localparam int BEN_W  = DATA_W / BYTE_W;

  logic              REQ_VALID;
  logic              REQ_READY;
  logic              REQ_WRITE;
  logic [ADDR_W-1:0] REQ_ADDR;
  logic [BEN_W-1:0]  REQ_BEN;
  logic [DATA_W-1:0] REQ_WDATA;
  logic              RSP_VALID;
  logic              RSP_READY;
  logic [DATA_W-1:0] RSP_RDATA;

  modport master (
    output REQ_VALID, REQ_WRITE, REQ_ADDR, REQ_BEN, REQ_WDATA, RSP_READY,
    input  REQ_READY, RSP_VALID, RSP_RDATA
  );

  modport slave (
    input  REQ_VALID, REQ_WRITE, REQ_ADDR, REQ_BEN, REQ_WDATA, RSP_READY,
    output REQ_READY, RSP_VALID, RSP_RDATA
  );

endinterface

// File: rtl/sram_sp_ctrl_sync_fifo.sv
// Synchronous FIFO with arbitrary (non power-of-two) depth and an occupancy count.
// The head entry is presented combinationally on pop_data.
module sync_fifo
  import sram_ctrl_pkg::*;
#(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 3,
  localparam int CNT_W = clog2(DEPTH + 1),
  localparam int PTR_W = (DEPTH > 1) ? clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= next_ptr(wr_ptr);
      if (pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is left unreset; entries are only observed once written.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign pop_data = mem[rd_ptr];
  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);

  a_no_overflow:  assert property (@(posedge clk) disable iff (!rst_n) push |-> !full);
  a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n) pop |-> !empty);

endmodule

// File: rtl/sram_sp_ctrl.sv
// Single-port SRAM controller: valid/ready requests in, macro driven in the
// acceptance cycle, read data buffered in a small FIFO with backpressure.
module sram_sp_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter  int DATA_W    = 32,
  parameter  int DEPTH     = 16384,
  parameter  int RSP_DEPTH = 3,
  localparam int ADDR_W    = clog2(DEPTH)
) (
  input  logic              CLK,
  input  logic              RESETn,
  sram_sp_ctrl_if.slave     bus,
  output logic              SRAM_CEN,
  output logic              SRAM_GWEN,
  output logic [DATA_W-1:0] SRAM_WEN,
  output logic [ADDR_W-1:0] SRAM_A,
  output logic [DATA_W-1:0] SRAM_D,
  input  logic [DATA_W-1:0] SRAM_Q
);

  localparam int CNT_W = clog2(RSP_DEPTH + 1);

  logic              inflight;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_full;
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_head;
  logic [CNT_W-1:0]  occupancy;
  logic              req_ready;
  logic              accept;
  logic              rd_accept;
  logic              wr_access;
  logic              pop;
  logic [ADDR_W-1:0] a_q;
  logic [DATA_W-1:0] d_q;

  // A slot is reserved for every read already in the macro, so the FIFO can never overflow.
  always_comb begin
    occupancy = fifo_count + CNT_W'(inflight);
    req_ready = RESETn && (occupancy < CNT_W'(RSP_DEPTH));
    accept    = bus.REQ_VALID && req_ready;
    rd_accept = accept && !bus.REQ_WRITE;
    wr_access = accept && bus.REQ_WRITE && (|bus.REQ_BEN);
  end

  always_comb begin
    SRAM_CEN  = !(rd_accept || wr_access);
    SRAM_GWEN = !wr_access;
    SRAM_WEN  = '1;
    SRAM_A    = a_q;
    SRAM_D    = d_q;
    if (rd_accept || wr_access) SRAM_A = bus.REQ_ADDR;
    if (wr_access) begin
      SRAM_WEN = DATA_W'(ben_to_wen(MAX_BEN_W'(bus.REQ_BEN)));
      SRAM_D   = bus.REQ_WDATA;
    end
  end

  // Address and data are held when idle so the macro pins do not toggle.
  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      inflight <= 1'b0;
      a_q      <= '0;
      d_q      <= '0;
    end else begin
      inflight <= rd_accept;
      if (rd_accept || wr_access) a_q <= bus.REQ_ADDR;
      if (wr_access)              d_q <= bus.REQ_WDATA;
    end
  end

  sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk       (CLK),
    .rst_n     (RESETn),
    .push      (inflight),
    .push_data (SRAM_Q),
    .pop       (pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign pop           = bus.RSP_VALID && bus.RSP_READY;
  assign bus.RSP_VALID = RESETn && !fifo_empty;
  assign bus.RSP_RDATA = fifo_head;
  assign bus.REQ_READY = req_ready;

  a_slot_reserved: assert property (@(posedge CLK) disable iff (!RESETn) inflight |-> !fifo_full);

endmodule

// File: tb/tb_sram_sp_ctrl.sv
// Directed bench for sram_sp_ctrl with a behavioural byte-maskable SRAM macro.
module tb_sram_sp_ctrl;

  localparam int DATA_W    = 32;
  localparam int DEPTH     = 16384;
  localparam int RSP_DEPTH = 3;
  localparam int ADDR_W    = 14;

  logic              CLK = 1'b0;
  logic              RESETn = 1'b0;
  logic              SRAM_CEN;
  logic              SRAM_GWEN;
  logic [DATA_W-1:0] SRAM_WEN;
  logic [ADDR_W-1:0] SRAM_A;
  logic [DATA_W-1:0] SRAM_D;
  logic [DATA_W-1:0] SRAM_Q = '0;
  logic [DATA_W-1:0] macro_mem [DEPTH];

  int compared   = 0;
  int mismatched = 0;

  always #5 CLK = ~CLK;

  sram_sp_ctrl_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

  sram_sp_ctrl #(
    .DATA_W    (DATA_W),
    .DEPTH     (DEPTH),
    .RSP_DEPTH (RSP_DEPTH)
  ) dut (
    .CLK       (CLK),
    .RESETn    (RESETn),
    .bus       (bus.slave),
    .SRAM_CEN  (SRAM_CEN),
    .SRAM_GWEN (SRAM_GWEN),
    .SRAM_WEN  (SRAM_WEN),
    .SRAM_A    (SRAM_A),
    .SRAM_D    (SRAM_D),
    .SRAM_Q    (SRAM_Q)
  );

  // Macro model: masked write or registered read on each enabled edge.
  always @(posedge CLK) begin
    if (!SRAM_CEN) begin
      if (!SRAM_GWEN)
        macro_mem[SRAM_A] <= (macro_mem[SRAM_A] & SRAM_WEN) | (SRAM_D & ~SRAM_WEN);
      else
        SRAM_Q <= macro_mem[SRAM_A];
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    compared = compared + 1;
    if (got !== exp) begin
      mismatched = mismatched + 1;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic write, input logic [ADDR_W-1:0] addr,
                               input logic [3:0] ben, input logic [31:0] wdata, input logic rsp_ready);
    bus.REQ_VALID = valid;
    bus.REQ_WRITE = write;
    bus.REQ_ADDR  = addr;
    bus.REQ_BEN   = ben;
    bus.REQ_WDATA = wdata;
    bus.RSP_READY = rsp_ready;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic sample();
    @(negedge CLK);
  endtask

  task automatic writeWord(input logic [ADDR_W-1:0] addr, input logic [3:0] ben, input logic [31:0] data);
    applyStimulus(1'b1, 1'b1, addr, ben, data, 1'b1);
    sample();
    tick();
  endtask

  task automatic readCheck(input string tag, input logic [ADDR_W-1:0] addr, input logic [31:0] exp);
    applyStimulus(1'b1, 1'b0, addr, 4'h0, 32'h0, 1'b1);
    sample();
    checkOutput({tag, "_cen"}, SRAM_CEN, 1'b0);
    checkOutput({tag, "_gwen"}, SRAM_GWEN, 1'b1);
    checkOutput({tag, "_wen"}, SRAM_WEN, 32'hFFFF_FFFF);
    tick();
    applyStimulus(1'b0, 1'b0, '0, 4'h0, 32'h0, 1'b1);
    sample();
    checkOutput({tag, "_early_valid"}, bus.RSP_VALID, 1'b0);
    tick();
    sample();
    checkOutput({tag, "_valid"}, bus.RSP_VALID, 1'b1);
    checkOutput({tag, "_rdata"}, bus.RSP_RDATA, exp);
    tick();
  endtask

  logic [31:0] seq_data [8];
  logic        stall_ready [5];
  int          acc;

  initial begin
    for (int i = 0; i < 8; i++) seq_data[i] = 32'h1000_0000 + 32'(i) * 32'h0000_0111;
    stall_ready = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

    // Reset held with a pending request
    RESETn = 1'b0;
    applyStimulus(1'b1, 1'b0, 14'h0010, 4'h0, 32'h0, 1'b1);
    for (int c = 0; c < 3; c++) begin
      sample();
      checkOutput("rst_req_ready", bus.REQ_READY, 1'b0);
      checkOutput("rst_cen", SRAM_CEN, 1'b1);
      checkOutput("rst_rsp_valid", bus.RSP_VALID, 1'b0);
      tick();
    end
    sample();
    checkOutput("rst_gwen", SRAM_GWEN, 1'b1);
    checkOutput("rst_wen", SRAM_WEN, 32'hFFFF_FFFF);
    checkOutput("rst_addr", SRAM_A, 14'h0000);
    checkOutput("rst_d", SRAM_D, 32'h0);
    tick();
    applyStimulus(1'b0, 1'b0, '0, 4'h0, 32'h0, 1'b1);
    RESETn = 1'b1;
    sample();
    checkOutput("post_rst_ready", bus.REQ_READY, 1'b1);
    tick();

    // Full write then read-after-write
    applyStimulus(1'b1, 1'b1, 14'h0010, 4'hF, 32'hDEAD_BEEF, 1'b1);
    sample();
    checkOutput("wr_cen", SRAM_CEN, 1'b0);
    checkOutput("wr_gwen", SRAM_GWEN, 1'b0);
    checkOutput("wr_wen", SRAM_WEN, 32'h0000_0000);
    checkOutput("wr_addr", SRAM_A, 14'h0010);
    checkOutput("wr_d", SRAM_D, 32'hDEAD_BEEF);
    tick();
    readCheck("rd_full", 14'h0010, 32'hDEAD_BEEF);

    // Partial write over a known word
    writeWord(14'h0020, 4'hF, 32'hAAAA_AAAA);
    applyStimulus(1'b1, 1'b1, 14'h0020, 4'b0101, 32'h1122_3344, 1'b1);
    sample();
    checkOutput("part_wen", SRAM_WEN, 32'hFF00_FF00);
    tick();
    readCheck("rd_part", 14'h0020, 32'hAA22_AA44);

    // Write with no byte enables: accepted, no macro access
    applyStimulus(1'b1, 1'b1, 14'h0010, 4'h0, 32'h1234_5678, 1'b1);
    sample();
    checkOutput("ben0_ready", bus.REQ_READY, 1'b1);
    checkOutput("ben0_cen", SRAM_CEN, 1'b1);
    checkOutput("ben0_addr_hold", SRAM_A, 14'h0020);
    tick();
    applyStimulus(1'b0, 1'b0, '0, 4'h0, 32'h0, 1'b1);
    sample();
    checkOutput("ben0_no_rsp", bus.RSP_VALID, 1'b0);
    tick();
    readCheck("rd_ben0", 14'h0010, 32'hDEAD_BEEF);

    // Back-to-back reads at full throughput
    for (int i = 0; i < 8; i++) writeWord(ADDR_W'(14'h0040 + i), 4'hF, seq_data[i]);
    for (int c = 0; c < 10; c++) begin
      if (c < 8) applyStimulus(1'b1, 1'b0, ADDR_W'(14'h0040 + c), 4'h0, 32'h0, 1'b1);
      else       applyStimulus(1'b0, 1'b0, '0, 4'h0, 32'h0, 1'b1);
      sample();
      if (c < 8) checkOutput("b2b_ready", bus.REQ_READY, 1'b1);
      checkOutput("b2b_valid", bus.RSP_VALID, (c >= 2));
      if (c >= 2) checkOutput("b2b_rdata", bus.RSP_RDATA, seq_data[c-2]);
      tick();
    end
    sample();
    checkOutput("b2b_idle_valid", bus.RSP_VALID, 1'b0);
    tick();

    // Backpressure: only RSP_DEPTH reads fit
    acc = 0;
    for (int c = 0; c < 5; c++) begin
      applyStimulus(1'b1, 1'b0, ADDR_W'(14'h0040 + acc), 4'h0, 32'h0, 1'b0);
      sample();
      checkOutput("bp_ready", bus.REQ_READY, stall_ready[c]);
      checkOutput("bp_valid", bus.RSP_VALID, (c >= 2));
      if (c >= 2) checkOutput("bp_rdata_stable", bus.RSP_RDATA, seq_data[0]);
      if (bus.REQ_READY) acc = acc + 1;
      tick();
    end
    checkOutput("bp_accepted", 64'(acc), 64'd3);
    applyStimulus(1'b0, 1'b0, '0, 4'h0, 32'h0, 1'b1);
    for (int d = 0; d < 3; d++) begin
      sample();
      checkOutput("drain_valid", bus.RSP_VALID, 1'b1);
      checkOutput("drain_rdata", bus.RSP_RDATA, seq_data[d]);
      checkOutput("drain_ready", bus.REQ_READY, (d > 0));
      tick();
    end
    sample();
    checkOutput("drain_empty", bus.RSP_VALID, 1'b0);
    tick();

    // Reset with two responses held
    for (int c = 0; c < 4; c++) begin
      if (c < 2) applyStimulus(1'b1, 1'b0, ADDR_W'(14'h0045 + c), 4'h0, 32'h0, 1'b0);
      else       applyStimulus(1'b0, 1'b0, '0, 4'h0, 32'h0, 1'b0);
      sample();
      if (c == 3) begin
        checkOutput("held_valid", bus.RSP_VALID, 1'b1);
        checkOutput("held_rdata", bus.RSP_RDATA, seq_data[5]);
        checkOutput("held_ready", bus.REQ_READY, 1'b1);
      end
      tick();
    end
    RESETn = 1'b0;
    tick();
    sample();
    checkOutput("midrst_valid", bus.RSP_VALID, 1'b0);
    checkOutput("midrst_ready", bus.REQ_READY, 1'b0);
    checkOutput("midrst_cen", SRAM_CEN, 1'b1);
    tick();
    RESETn = 1'b1;
    bus.RSP_READY = 1'b1;
    sample();
    checkOutput("flushed_valid", bus.RSP_VALID, 1'b0);
    checkOutput("flushed_ready", bus.REQ_READY, 1'b1);
    tick();
    readCheck("rd_after_rst", 14'h0010, 32'hDEAD_BEEF);
    sample();
    checkOutput("final_idle", bus.RSP_VALID, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
